irq_pending_ctrl: RTL and testbench
===================================

// Module: irq_pending_ctrl
// PURPOSE
//  Interrupt front end: captures N request lines into a pending register, masks them,
//  picks the highest-index unmasked pending request and presents its 3-bit id to the
//  service side over a valid/ack handshake, then holds an in-service lock until EOI.
//  It is the registered, handshaked stage that feeds the downstream request-service logic.
// PARAMETERS
//  N     8   number of request lines; must equal 2**ID_W
//  ID_W  3   width of irq_id
// PORTS
//  clk       in   1     rising-edge clock
//  rst       in   1     asynchronous, active-high reset
//  en        in   1     1 = new requests may be presented; 0 = no new presentation
//  irq_in    in   N     raw request lines, synchronous to clk
//  irq_mask  in   N     1 = line masked (still latched as pending, never selected)
//  irq_ack   in   1     service side accepts the presented id
//  eoi       in   1     end of interrupt for the id currently in service
//  irq_valid out  1     irq_id is valid and stable
//  irq_id    out  ID_W  index of the selected request, highest index wins
//  pending   out  N     pending register contents
//  busy      out  1     1 in REQ or SERV
// BEHAVIOUR
//  - Reset: pending=0, irq_valid=0, irq_id=0, busy=0, state=IDLE, internal irq_in history=0.
//  - Pending set: bit i is set on the clk edge after its set condition (see CONFIGURATION);
//    a set condition and an ack-clear on the same bit in the same cycle leave the bit set.
//  - Selection: sel = highest i with pending[i] & ~irq_mask[i]; combinational, not registered.
//  - FSM IDLE/REQ/SERV:
//    IDLE: if en & any unmasked pending: -> REQ, irq_id<=sel, irq_valid<=1 (1-cycle latency).
//    REQ : irq_valid=1, irq_id frozen even if a higher request or mask change arrives.
//          On irq_ack: pending[irq_id]<=0, irq_valid<=0, -> SERV. en has no effect in REQ.
//    SERV: irq_id held, irq_valid=0. On eoi: -> IDLE. The next request can be presented
//          on the following edge at the earliest (min 1 IDLE cycle between presentations).
//  - irq_ack outside REQ and eoi outside SERV are ignored.
//  - irq_ack and eoi asserted in the same REQ cycle: only ack is taken; eoi is ignored.
//  - All lines masked or en=0 in IDLE: stay in IDLE, irq_valid=0, pending keeps accumulating.
//  - Reset asserted mid-handshake: immediate return to reset values; the lost request
//    is not replayed.
//  - busy = (state != IDLE).
// CONFIGURATION
//  IRQ_EDGE_DETECT_EN defined: set condition = rising edge of irq_in[i] (irq_in & ~irq_in_d).
//    A line held high sets pending only once.
//  IRQ_EDGE_DETECT_EN undefined: level mode; set condition = irq_in[i]==1 on every cycle.
//    A still-high line re-pends right after its ack clears it. irq_in_d is not built.
// STRUCTURE
//  Shared package irq_pkg: N/ID_W defaults and the state encoding
//  (IDLE=2'd0, REQ=2'd1, SERV=2'd2).
//  One sub-module, irq_prio_sel: combinational N->ID_W highest-index select with an
//  any_valid output. The FSM, pending register and edge history stay in the top module.
// TESTING
//  1 reset: rst=1 mid-REQ with pending=8'h90 -> next cycle pending=0, irq_valid=0, busy=0.
//  2 priority: irq_in=8'h14 for one cycle, en=1 -> irq_valid=1 with irq_id=3'd4; ack
//    -> pending=8'h04; eoi -> next presentation irq_id=3'd2.
//  3 no preemption: in REQ with id=3, raise irq_in[7] -> irq_id stays 3 until ack;
//    after eoi the presentation is id=7.
//  4 mask: pending=8'h81, irq_mask=8'h80 -> id=0 presented; pending[7] stays set;
//    unmask -> id=7 after eoi.
//  5 mode: hold irq_in[5]=1 for 20 cycles with repeated ack/eoi -> edge build gives
//    one presentation; level build presents id=5 after every eoi.
//  6 stray handshake: irq_ack in IDLE, eoi in REQ, and en=0 with pending=8'h01 ->
//    state, pending and outputs are unchanged.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared defaults and state encoding for the interrupt pending controller.
package irq_pkg;

    localparam int IRQ_N    = 8;
    localparam int IRQ_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational highest-index select over an N-bit request vector.
module irq_prio_sel #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    i_req,
    output logic [ID_W-1:0] o_id,
    output logic            o_any
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        o_id  = '0;
        o_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_req[i]) begin
                o_id  = ID_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: pending capture, masked priority select, valid/ack + EOI lock.
// Optional build macro IRQ_EDGE_DETECT_EN selects rising-edge capture instead of level capture.
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int N    = IRQ_N,
    parameter int ID_W = IRQ_ID_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    irq_in,
    input  logic [N-1:0]    irq_mask,
    input  logic            irq_ack,
    input  logic            eoi,
    output logic            irq_valid,
    output logic [ID_W-1:0] irq_id,
    output logic [N-1:0]    pending,
    output logic            busy
);

    irq_state_t      r_state;
    irq_state_t      w_state_nxt;
    logic [N-1:0]    r_pending;
    logic [ID_W-1:0] r_id;
    logic [N-1:0]    w_set;
    logic [N-1:0]    w_clr;
    logic [ID_W-1:0] w_sel;
    logic            w_any;
    logic            w_load;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N-1:0] r_irq_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_irq_d <= '0;
        else     r_irq_d <= irq_in;
    end

    assign w_set = irq_in & ~r_irq_d;
`else
    assign w_set = irq_in;
`endif

    irq_prio_sel #(
        .N    (N),
        .ID_W (ID_W)
    ) u_sel (
        .i_req (r_pending & ~irq_mask),
        .o_id  (w_sel),
        .o_any (w_any)
    );

    // Ack clears only the presented bit; a same-cycle set wins because it is OR-ed in last.
    assign w_clr = (r_state == REQ && irq_ack) ? ({{(N-1){1'b0}}, 1'b1} << r_id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pending <= '0;
        else     r_pending <= (r_pending & ~w_clr) | w_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_id <= '0;
        else if (w_load) r_id <= w_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && w_any) begin
                    w_state_nxt = REQ;
                    w_load      = 1'b1;
                end
            end
            REQ:     if (irq_ack) w_state_nxt = SERV;
            SERV:    if (eoi)     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irq_valid = (r_state == REQ);
        busy      = (r_state != IDLE);
        irq_id    = r_id;
        pending   = r_pending;
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Randomized + directed bench for irq_pending_ctrl with a behavioural reference model.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] irq_in = '0;
    logic [7:0] irq_mask = '0;
    logic       irq_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic       busy;

    int checks = 0;
    int errors = 0;

    irq_pending_ctrl #(.N(8), .ID_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .irq_in    (irq_in),
        .irq_mask  (irq_mask),
        .irq_ack   (irq_ack),
        .eoi       (eoi),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: m_phase 0 = nothing presented, 1 = id offered, 2 = id in service.
    logic [7:0] m_pend, m_prev;
    logic [2:0] m_id;
    int         m_phase;
    logic [7:0] n_pend;
    logic [2:0] n_id;
    int         n_phase;

    function automatic int highest(input logic [7:0] v);
        int h;
        h = -1;
        for (int i = 0; i < 8; i++) if (v[i]) h = i;
        return h;
    endfunction

    always_comb begin
        logic [7:0] setv;
        logic [7:0] clrv;
        int         h;
        n_pend  = m_pend;
        n_id    = m_id;
        n_phase = m_phase;
        clrv    = '0;
`ifdef IRQ_EDGE_DETECT_EN
        setv = irq_in & ~m_prev;
`else
        setv = irq_in;
`endif
        h = highest(m_pend & ~irq_mask);
        if (m_phase == 0 && en && h >= 0) begin
            n_id    = h[2:0];
            n_phase = 1;
        end else if (m_phase == 1 && irq_ack) begin
            clrv[m_id] = 1'b1;
            n_phase    = 2;
        end else if (m_phase == 2 && eoi) begin
            n_phase = 0;
        end
        n_pend = (m_pend & ~clrv) | setv;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend  <= '0;
            m_prev  <= '0;
            m_id    <= '0;
            m_phase <= 0;
        end else begin
            m_pend  <= n_pend;
            m_prev  <= irq_in;
            m_id    <= n_id;
            m_phase <= n_phase;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_valid",   32'(irq_valid), 32'(m_phase == 1));
        chk("model_busy",    32'(busy),      32'(m_phase != 0));
        chk("model_id",      32'(irq_id),    32'(m_id));
        chk("model_pending", 32'(pending),   32'(m_pend));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake_done();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        eoi = 1'b1;     step(); eoi = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_in = v; step(); irq_in = '0;
    endtask

    int presents;

    initial begin
        step(); step();
        rst = 1'b0;
        en  = 1'b1;
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_busy",    32'(busy),    32'h0);

        // Priority: 0x14 presents 4 first, then 2.
        pulse(8'h14);
        step();
        chk("prio_valid", 32'(irq_valid), 32'h1);
        chk("prio_id4",   32'(irq_id),    32'h4);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("prio_pend_after_ack", 32'(pending), 32'h04);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("prio_idle_gap", 32'(busy), 32'h0);
        step();
        chk("prio_id2", 32'(irq_id), 32'h2);
        handshake_done();
        step();

        // No preemption: id 3 stays while 7 arrives.
        pulse(8'h08);
        step();
        pulse(8'h80);
        chk("nopre_id3",  32'(irq_id),  32'h3);
        chk("nopre_pend", 32'(pending), 32'h88);
        handshake_done();
        step();
        chk("nopre_id7", 32'(irq_id), 32'h7);
        handshake_done();
        step();

        // Mask: 7 masked, 0 presented, 7 after unmask.
        irq_mask = 8'h80;
        pulse(8'h81);
        step();
        chk("mask_id0",   32'(irq_id),  32'h0);
        chk("mask_pend",  32'(pending), 32'h81);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("mask_pend7", 32'(pending), 32'h80);
        irq_mask = 8'h00;
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        chk("mask_id7", 32'(irq_id), 32'h7);
        handshake_done();
        step();

        // Stray handshakes.
        en = 1'b0;
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("stray_ack_busy", 32'(busy), 32'h0);
        pulse(8'h01);
        step(); step();
        chk("stray_en0_pend",  32'(pending),   32'h01);
        chk("stray_en0_valid", 32'(irq_valid), 32'h0);
        en = 1'b1; step();
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("stray_eoi_valid", 32'(irq_valid), 32'h1);
        irq_ack = 1'b1; eoi = 1'b1; step(); irq_ack = 1'b0; eoi = 1'b0;
        step();
        chk("ack_eoi_serv", 32'(busy), 32'h1);
        eoi = 1'b1; step(); eoi = 1'b0;
        step();

        // Mode: line 5 held high for 20 cycles.
        presents = 0;
        irq_in = 8'h20;
        for (int k = 0; k < 20; k++) begin
            if (irq_valid) begin irq_ack = 1'b1; presents++; end
            else if (busy) eoi = 1'b1;
            step();
            irq_ack = 1'b0; eoi = 1'b0;
        end
        irq_in = '0;
`ifdef IRQ_EDGE_DETECT_EN
        chk("mode_edge_once", 32'(presents), 32'd1);
`else
        chk("mode_level_many", 32'(presents >= 5), 32'h1);
`endif
        for (int k = 0; k < 12 && (busy || pending != 0); k++) begin
            if (irq_valid) irq_ack = 1'b1;
            else if (busy) eoi = 1'b1;
            step();
            irq_ack = 1'b0; eoi = 1'b0;
        end
        chk("mode_drained", 32'({busy, pending}), 32'h0);

        // Reset mid-REQ with pending 0x90.
        pulse(8'h90);
        step();
        chk("rst_pre_valid", 32'(irq_valid), 32'h1);
        chk("rst_pre_pend",  32'(pending),   32'h90);
        rst = 1'b1; step();
        chk("rst_pend",  32'(pending),   32'h0);
        chk("rst_valid", 32'(irq_valid), 32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        rst = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            irq_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
            en      = ($urandom_range(0, 7) != 0);
            irq_ack = ($urandom_range(0, 2) == 0);
            eoi     = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) irq_mask = 8'($urandom & $urandom);
            rst     = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; irq_ack = 1'b0; eoi = 1'b0; irq_in = '0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
